product_accumulator: RTL

//  Downstream stage of the 4x4 shift-add multiplier. Accepts one 8-bit product
//  per valid/ready handshake and sums COUNT consecutive products.

---
 rtl/product_accumulator.sv | 104 ++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// Sums COUNT valid/ready products into one handshaked result.
// Optional macro ACC_SATURATE_EN clamps the sum instead of wrapping.
module product_accumulator #(
  parameter int PW    = 8,
  parameter int ACC_W = 16,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    in_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             overflow
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_sum;
  logic [7:0]       r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_ovf;

  logic [ACC_W:0]   w_add;
  logic [ACC_W-1:0] w_next;
  logic             w_take;
  logic             w_last;

  // Widened add so the carry out of the top bit is visible.
  assign w_add = {1'b0, r_acc} + (ACC_W+1)'(in_prod);

`ifdef ACC_SATURATE_EN
  // A carry clamps to all-ones; all-ones plus anything stays clamped.
  assign w_next = w_add[ACC_W] ? '1 : w_add[ACC_W-1:0];
`else
  assign w_next = w_add[ACC_W-1:0];
`endif

  assign w_take = in_valid & r_in_ready;
  assign w_last = (r_cnt == 8'(COUNT - 1));

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign overflow  = r_ovf;

  // Two-state accumulate/hold FSM; clear beats both handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (clear) begin
      r_state     <= ACC;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      unique case (r_state)
        ACC: begin
          if (w_take) begin
            r_acc <= w_next;
            if (w_add[ACC_W]) r_ovf <= 1'b1;
            if (w_last) begin
              r_cnt       <= '0;
              r_sum       <= w_next;
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_state     <= ACC;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

endmodule
